// File: rtl/tri_edge_sched.sv
// tri_edge_sched: draws a triangle outline by issuing v0->v1, v1->v2 and v2->v0 to one shared line engine.
// Define TRI_SCHED_TIMEOUT_EN to enable the per-edge watchdog and the sticky err flag.
module tri_edge_sched #(
    parameter int          COORD_W     = 32,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tri_valid,
    output logic                      tri_ready,
    input  logic signed [COORD_W-1:0] x0,
    input  logic signed [COORD_W-1:0] y0,
    input  logic signed [COORD_W-1:0] x1,
    input  logic signed [COORD_W-1:0] y1,
    input  logic signed [COORD_W-1:0] x2,
    input  logic signed [COORD_W-1:0] y2,
    output logic                      ln_start,
    output logic signed [COORD_W-1:0] ln_x1,
    output logic signed [COORD_W-1:0] ln_y1,
    output logic signed [COORD_W-1:0] ln_x2,
    output logic signed [COORD_W-1:0] ln_y2,
    output logic                      ln_swap,
    output logic                      ln_neg_dy,
    input  logic                      ln_finish,
    output logic [1:0]                edge_idx,
    output logic                      busy,
    output logic                      tri_done,
    output logic                      err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_NEXT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                    state_r;
    logic signed [COORD_W-1:0] vx0_r, vy0_r, vx1_r, vy1_r, vx2_r, vy2_r;
    logic signed [COORD_W-1:0] ln_x1_r, ln_y1_r, ln_x2_r, ln_y2_r;
    logic                      ln_start_r, ln_swap_r, ln_neg_dy_r;
    logic                      tri_ready_r, busy_r, tri_done_r, fin_prev_r;
    logic [1:0]                edge_idx_r, nxt_edge_s;
    logic signed [COORD_W-1:0] ax_s, ay_s, bx_s, by_s;
    logic signed [COORD_W-1:0] p1x_s, p1y_s, p2x_s, p2y_s;
    logic                      swap_s, neg_dy_s, rise_s, timeout_s, edge_done_s;

    // Select the endpoints of the edge about to be issued and put them in (x, y) lexicographic order.
    always_comb begin
        nxt_edge_s = 2'd0;
        if (state_r == S_IDLE) begin
            nxt_edge_s = 2'd0;
        end else begin
            nxt_edge_s = edge_idx_r + 2'd1;
        end
        ax_s = x0;
        ay_s = y0;
        bx_s = x1;
        by_s = y1;
        case (nxt_edge_s)
            2'd1: begin
                ax_s = vx1_r; ay_s = vy1_r; bx_s = vx2_r; by_s = vy2_r;
            end
            2'd2: begin
                ax_s = vx2_r; ay_s = vy2_r; bx_s = vx0_r; by_s = vy0_r;
            end
            default: begin
                // Edge 0 is loaded in the accept cycle, straight from the vertex inputs.
                ax_s = x0; ay_s = y0; bx_s = x1; by_s = y1;
            end
        endcase
        swap_s = (ax_s > bx_s) || ((ax_s == bx_s) && (ay_s > by_s));
        if (swap_s) begin
            p1x_s = bx_s; p1y_s = by_s; p2x_s = ax_s; p2y_s = ay_s;
        end else begin
            p1x_s = ax_s; p1y_s = ay_s; p2x_s = bx_s; p2y_s = by_s;
        end
        neg_dy_s = (p2y_s < p1y_s);
    end

    assign rise_s      = ln_finish & ~fin_prev_r;
    assign edge_done_s = (state_r == S_WAIT) & (rise_s | timeout_s);

    // Edge sequencer: accept, issue, wait for a finish rise, advance, signal done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            tri_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            tri_done_r  <= 1'b0;
            ln_start_r  <= 1'b0;
            edge_idx_r  <= 2'd0;
            fin_prev_r  <= 1'b0;
            ln_x1_r     <= '0;
            ln_y1_r     <= '0;
            ln_x2_r     <= '0;
            ln_y2_r     <= '0;
            ln_swap_r   <= 1'b0;
            ln_neg_dy_r <= 1'b0;
            vx0_r <= '0; vy0_r <= '0; vx1_r <= '0; vy1_r <= '0; vx2_r <= '0; vy2_r <= '0;
        end else begin
            fin_prev_r <= ln_finish;
            case (state_r)
                S_IDLE: begin
                    if (tri_valid && tri_ready_r) begin
                        vx0_r <= x0; vy0_r <= y0; vx1_r <= x1; vy1_r <= y1; vx2_r <= x2; vy2_r <= y2;
                        edge_idx_r  <= 2'd0;
                        busy_r      <= 1'b1;
                        tri_ready_r <= 1'b0;
                        ln_start_r  <= 1'b1;
                        ln_x1_r     <= p1x_s;
                        ln_y1_r     <= p1y_s;
                        ln_x2_r     <= p2x_s;
                        ln_y2_r     <= p2y_s;
                        ln_swap_r   <= swap_s;
                        ln_neg_dy_r <= neg_dy_s;
                        state_r     <= S_ISSUE;
                    end else begin
                        tri_ready_r <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    ln_start_r <= 1'b0;
                    state_r    <= S_WAIT;
                end
                S_WAIT: begin
                    if (edge_done_s) begin
                        if (edge_idx_r == 2'd2) begin
                            tri_done_r <= 1'b1;
                            state_r    <= S_DONE;
                        end else begin
                            state_r <= S_NEXT;
                        end
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_NEXT: begin
                    edge_idx_r  <= edge_idx_r + 2'd1;
                    ln_start_r  <= 1'b1;
                    ln_x1_r     <= p1x_s;
                    ln_y1_r     <= p1y_s;
                    ln_x2_r     <= p2x_s;
                    ln_y2_r     <= p2y_s;
                    ln_swap_r   <= swap_s;
                    ln_neg_dy_r <= neg_dy_s;
                    state_r     <= S_ISSUE;
                end
                S_DONE: begin
                    tri_done_r  <= 1'b0;
                    busy_r      <= 1'b0;
                    tri_ready_r <= 1'b1;
                    edge_idx_r  <= 2'd0;
                    state_r     <= S_IDLE;
                end
                default: begin
                    state_r     <= S_IDLE;
                    tri_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    tri_done_r  <= 1'b0;
                    ln_start_r  <= 1'b0;
                    edge_idx_r  <= 2'd0;
                end
            endcase
        end
    end

`ifdef TRI_SCHED_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] wait_cnt_r;
    logic             err_r;

    assign timeout_s = (state_r == S_WAIT) && (wait_cnt_r == CNT_W'(TIMEOUT_CYC - 1));
    assign err       = err_r;

    // Watchdog: restarts with each job, counts WAIT cycles, latches err when an edge times out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= '0;
            err_r      <= 1'b0;
        end else if (state_r == S_ISSUE) begin
            wait_cnt_r <= '0;
        end else if (state_r == S_WAIT) begin
            wait_cnt_r <= wait_cnt_r + 1'b1;
            if (timeout_s && !rise_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end
`else
    logic unused_timeout_s;

    assign timeout_s        = 1'b0;
    assign err              = 1'b0;
    assign unused_timeout_s = (TIMEOUT_CYC == 32'd0);
`endif

    assign tri_ready = tri_ready_r;
    assign busy      = busy_r;
    assign tri_done  = tri_done_r;
    assign edge_idx  = edge_idx_r;
    assign ln_start  = ln_start_r;
    assign ln_x1     = ln_x1_r;
    assign ln_y1     = ln_y1_r;
    assign ln_x2     = ln_x2_r;
    assign ln_y2     = ln_y2_r;
    assign ln_swap   = ln_swap_r;
    assign ln_neg_dy = ln_neg_dy_r;

endmodule

// File: tb/tb_tri_edge_sched.sv
// Bench for tri_edge_sched: random triangles against a job-list model, with a behavioural line engine.
// Covers the TRI_SCHED_TIMEOUT_EN watchdog when that macro is defined.
module tb_tri_edge_sched;

`ifdef TRI_SCHED_TIMEOUT_EN
    localparam int unsigned TO_CYC = 16;
`else
    localparam int unsigned TO_CYC = 4096;
`endif

    typedef struct packed {
        logic [1:0]         eidx;
        logic signed [31:0] x1;
        logic signed [31:0] y1;
        logic signed [31:0] x2;
        logic signed [31:0] y2;
        logic               swap;
        logic               neg;
    } job_t;

    logic clk = 1'b0;
    logic rst_n, tri_valid, tri_ready, ln_start, ln_swap, ln_neg_dy;
    logic ln_finish = 1'b0;
    logic busy, tri_done, err;
    logic [1:0] edge_idx;
    logic signed [31:0] x0, y0, x1, y1, x2, y2, ln_x1, ln_y1, ln_x2, ln_y2;

    int cyc = 0;
    int checks = 0;
    int passes = 0;
    int tx[3], ty[3];
    int eng_lat = 4, eng_drop = 0, eng_hang_job = -1;
    int eng_cd = 0, eng_dd = 0, err_cyc = -1;
    bit eng_hang_now = 1'b0;
    job_t mon_j;
    job_t jobs_q[$];
    int start_q[$], rise_q[$], done_q[$], acc_q[$];

    tri_edge_sched #(.COORD_W(32), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .ln_start(ln_start), .ln_x1(ln_x1), .ln_y1(ln_y1), .ln_x2(ln_x2), .ln_y2(ln_y2),
        .ln_swap(ln_swap), .ln_neg_dy(ln_neg_dy), .ln_finish(ln_finish),
        .edge_idx(edge_idx), .busy(busy), .tri_done(tri_done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line engine and event logger: drops finish some cycles after a start, raises it after the latency.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                eng_cd = 0; eng_dd = 0; ln_finish = 1'b0;
            end else begin
                if (tri_valid && tri_ready) acc_q.push_back(cyc);
                if (tri_done) done_q.push_back(cyc);
                if (err && err_cyc < 0) err_cyc = cyc;
                if (ln_start) begin
                    mon_j.eidx = edge_idx; mon_j.x1 = ln_x1; mon_j.y1 = ln_y1;
                    mon_j.x2 = ln_x2; mon_j.y2 = ln_y2; mon_j.swap = ln_swap; mon_j.neg = ln_neg_dy;
                    jobs_q.push_back(mon_j);
                    eng_hang_now = (start_q.size() == eng_hang_job);
                    start_q.push_back(cyc);
                    eng_cd = eng_lat; eng_dd = eng_drop;
                    if (eng_drop == 0) ln_finish = 1'b0;
                end else begin
                    if (eng_dd > 0) begin
                        eng_dd--;
                        if (eng_dd == 0) ln_finish = 1'b0;
                    end
                    if (eng_cd > 0) begin
                        eng_cd--;
                        if (eng_cd == 0 && !eng_hang_now) begin
                            ln_finish = 1'b1;
                            rise_q.push_back(cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench time limit");
    end

    // Expected job for edge A->B: lexicographically smaller point first, swap when that is B.
    function automatic job_t model_job(input int ax, input int ay, input int bx, input int by, input int k);
        job_t j;
        bit a_first;
        a_first = (ax < bx) || (ax == bx && ay <= by);
        j.eidx = 2'(k);
        j.swap = !a_first;
        if (a_first) begin
            j.x1 = ax; j.y1 = ay; j.x2 = bx; j.y2 = by; j.neg = (by < ay);
        end else begin
            j.x1 = bx; j.y1 = by; j.x2 = ax; j.y2 = ay; j.neg = (ay < by);
        end
        return j;
    endfunction

    function automatic string job_str(input job_t j);
        return $sformatf("e%0d (%0d,%0d)-(%0d,%0d) swap%0b neg%0b", j.eidx, j.x1, j.y1, j.x2, j.y2, j.swap, j.neg);
    endfunction

    task automatic clear_logs();
        jobs_q.delete(); start_q.delete(); rise_q.delete(); done_q.delete(); acc_q.delete();
        err_cyc = -1;
    endtask

    task automatic drive_vertices();
        x0 = tx[0]; y0 = ty[0]; x1 = tx[1]; y1 = ty[1]; x2 = tx[2]; y2 = ty[2];
    endtask

    task automatic random_tri(input bit wide);
        for (int v = 0; v < 3; v++) begin
            if (wide) begin
                tx[v] = int'($urandom()); ty[v] = int'($urandom());
            end else begin
                tx[v] = int'($urandom_range(12)) - 6; ty[v] = int'($urandom_range(12)) - 6;
            end
        end
    endtask

    task automatic run_tri(input int lat, input int drop, input int hang);
        int n;
        clear_logs();
        eng_lat = lat; eng_drop = drop; eng_hang_job = hang;
        @(posedge clk); #1;
        drive_vertices();
        tri_valid = 1'b1;
        n = 0;
        while (acc_q.size() == 0 && n < 20) begin @(posedge clk); #1; n++; end
        tri_valid = 1'b0;
        while (done_q.size() == 0 && n < 600) begin @(posedge clk); #1; n++; end
        checks++;
        if (done_q.size() == 0) $display("FAIL run_tri_bound: no tri_done after %0d cycles (lat %0d)", n, lat);
        else passes++;
    endtask

    task automatic test_reset();
        int n;
        job_t e;
        checks++;
        if ({tri_ready, busy, tri_done, ln_start, edge_idx, ln_swap, ln_neg_dy, err} !== 9'b1_0_0_0_00_0_0_0)
            $display("FAIL reset_ctrl: got %b expected 100000000",
                     {tri_ready, busy, tri_done, ln_start, edge_idx, ln_swap, ln_neg_dy, err});
        else passes++;
        checks++;
        if ({ln_x1, ln_y1, ln_x2, ln_y2} !== 128'd0) $display("FAIL reset_coords: got %h expected 0", {ln_x1, ln_y1, ln_x2, ln_y2});
        else passes++;

        clear_logs();
        eng_lat = 6; eng_drop = 0; eng_hang_job = -1;
        random_tri(1'b0);
        @(posedge clk); #1;
        drive_vertices();
        tri_valid = 1'b1;
        n = 0;
        while (acc_q.size() == 0 && n < 20) begin @(posedge clk); #1; n++; end
        tri_valid = 1'b0;
        while (start_q.size() < 2 && n < 100) begin @(posedge clk); #1; n++; end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (edge_idx !== 2'd1) $display("FAIL pre_reset_edge: got %0d expected 1", edge_idx);
        else passes++;
        random_tri(1'b0);
        drive_vertices();
        tri_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tri_ready, busy, ln_start, edge_idx, tri_done} !== 6'b1_0_0_00_0)
            $display("FAIL reset_midwait: got %b expected 100000", {tri_ready, busy, ln_start, edge_idx, tri_done});
        else passes++;
        checks++;
        if ({ln_x1, ln_y2} !== 64'd0) $display("FAIL reset_midwait_coords: got %h expected 0", {ln_x1, ln_y2});
        else passes++;
        clear_logs();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({ln_start, tri_ready} !== 2'b01) $display("FAIL reset_hold%0d: start,ready got %b expected 01", i, {ln_start, tri_ready});
            else passes++;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ln_start !== 1'b0) $display("FAIL reset_release_start: got %b expected 0", ln_start);
        else passes++;
        @(posedge clk); #1;
        tri_valid = 1'b0;
        n = 0;
        while (done_q.size() == 0 && n < 200) begin @(posedge clk); #1; n++; end
        checks++;
        if ({jobs_q.size(), start_q[0]} !== {32'd3, acc_q[0] + 1})
            $display("FAIL reset_first_tri: jobs %0d start %0d, expected 3 jobs start %0d", jobs_q.size(), start_q[0], acc_q[0] + 1);
        else passes++;
        e = model_job(tx[0], ty[0], tx[1], ty[1], 0);
        checks++;
        if (jobs_q[0] !== e) $display("FAIL reset_first_job: got %s expected %s", job_str(jobs_q[0]), job_str(e));
        else passes++;
    endtask

    task automatic test_edges();
        job_t e;
        int lat, drop;
        for (int t = 0; t < 24; t++) begin
            case (t)
                0: begin
                    tx = '{1, 20, 5}; ty = '{2, 10, 30}; lat = 10; drop = 0;
                end
                1: begin
                    tx = '{3, 3, 3}; ty = '{3, 3, 3}; lat = 4; drop = 0;
                end
                2: begin
                    random_tri(1'b0); lat = 9; drop = 6;
                end
                default: begin
                    random_tri(t % 4 == 3);
                    if (t % 5 == 0) tx[1] = tx[0];
                    lat = int'($urandom_range(1, 12));
                    drop = int'($urandom_range(0, lat - 1));
                end
            endcase
            run_tri(lat, drop, -1);
            checks++;
            if (jobs_q.size() != 3) $display("FAIL tri%0d_job_count: got %0d expected 3", t, jobs_q.size());
            else passes++;
            for (int k = 0; k < 3; k++) begin
                e = model_job(tx[k], ty[k], tx[(k + 1) % 3], ty[(k + 1) % 3], k);
                checks++;
                if (jobs_q[k] !== e) $display("FAIL tri%0d_job%0d: got %s expected %s", t, k, job_str(jobs_q[k]), job_str(e));
                else passes++;
            end
            checks++;
            if (start_q[0] !== acc_q[0] + 1) $display("FAIL tri%0d_first_start: got %0d expected %0d", t, start_q[0], acc_q[0] + 1);
            else passes++;
            checks++;
            if (rise_q.size() != 3) $display("FAIL tri%0d_rise_count: got %0d expected 3", t, rise_q.size());
            else passes++;
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (start_q[k] !== rise_q[k - 1] + 2)
                    $display("FAIL tri%0d_start%0d: got %0d expected %0d (lat %0d drop %0d)", t, k, start_q[k], rise_q[k - 1] + 2, lat, drop);
                else passes++;
            end
            checks++;
            if (done_q[0] !== rise_q[2] + 1) $display("FAIL tri%0d_done_cycle: got %0d expected %0d", t, done_q[0], rise_q[2] + 1);
            else passes++;
            checks++;
            if ({tri_ready, busy, edge_idx, tri_done, ln_start, err} !== 7'b1_0_00_0_0_0)
                $display("FAIL tri%0d_idle_after: got %b expected 1000000", t, {tri_ready, busy, edge_idx, tri_done, ln_start, err});
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int ax[3], ay[3];
        job_t e;
        clear_logs();
        eng_lat = int'($urandom_range(2, 8)); eng_drop = 0; eng_hang_job = -1;
        random_tri(1'b0);
        ax = tx; ay = ty;
        @(posedge clk); #1;
        drive_vertices();
        tri_valid = 1'b1;
        n = 0;
        while (acc_q.size() == 0 && n < 20) begin @(posedge clk); #1; n++; end
        random_tri(1'b1);
        drive_vertices();
        while (acc_q.size() < 2 && n < 600) begin @(posedge clk); #1; n++; end
        tri_valid = 1'b0;
        while (done_q.size() < 2 && n < 900) begin @(posedge clk); #1; n++; end
        checks++;
        if (done_q.size() != 2 || acc_q.size() != 2)
            $display("FAIL b2b_counts: accepts %0d dones %0d, expected 2 and 2", acc_q.size(), done_q.size());
        else passes++;
        checks++;
        if (acc_q[1] !== done_q[0] + 1) $display("FAIL b2b_second_accept: got cycle %0d expected %0d", acc_q[1], done_q[0] + 1);
        else passes++;
        checks++;
        if (jobs_q.size() != 6) $display("FAIL b2b_job_count: got %0d expected 6", jobs_q.size());
        else passes++;
        for (int k = 0; k < 6; k++) begin
            if (k < 3) e = model_job(ax[k], ay[k], ax[(k + 1) % 3], ay[(k + 1) % 3], k);
            else e = model_job(tx[k - 3], ty[k - 3], tx[(k - 2) % 3], ty[(k - 2) % 3], k - 3);
            checks++;
            if (jobs_q[k] !== e) $display("FAIL b2b_job%0d: got %s expected %s", k, job_str(jobs_q[k]), job_str(e));
            else passes++;
        end
    endtask

`ifdef TRI_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        job_t e;
        checks++;
        if (err !== 1'b0) $display("FAIL to_err_before: got %b expected 0", err);
        else passes++;
        random_tri(1'b0);
        run_tri(5, 0, 1);
        checks++;
        if (start_q.size() != 3 || rise_q.size() != 2)
            $display("FAIL to_counts: starts %0d rises %0d, expected 3 and 2", start_q.size(), rise_q.size());
        else passes++;
        checks++;
        if (start_q[2] !== start_q[1] + int'(TO_CYC) + 2)
            $display("FAIL to_edge2_start: got %0d expected %0d", start_q[2], start_q[1] + int'(TO_CYC) + 2);
        else passes++;
        checks++;
        if (err_cyc < start_q[1] + int'(TO_CYC) || err_cyc > start_q[1] + int'(TO_CYC) + 1)
            $display("FAIL to_err_cycle: got %0d expected %0d..%0d", err_cyc, start_q[1] + int'(TO_CYC), start_q[1] + int'(TO_CYC) + 1);
        else passes++;
        checks++;
        if (done_q[0] !== rise_q[1] + 1) $display("FAIL to_done_cycle: got %0d expected %0d", done_q[0], rise_q[1] + 1);
        else passes++;
        e = model_job(tx[2], ty[2], tx[0], ty[0], 2);
        checks++;
        if (jobs_q[2] !== e) $display("FAIL to_edge2_job: got %s expected %s", job_str(jobs_q[2]), job_str(e));
        else passes++;
        random_tri(1'b0);
        run_tri(3, 0, -1);
        checks++;
        if ({err, 8'(jobs_q.size())} !== {1'b1, 8'd3}) $display("FAIL to_err_sticky: err %b jobs %0d, expected 1 and 3", err, jobs_q.size());
        else passes++;
    endtask
`endif

    initial begin
        rst_n = 1'b0; tri_valid = 1'b0;
        x0 = 32'sd0; y0 = 32'sd0; x1 = 32'sd0; y1 = 32'sd0; x2 = 32'sd0; y2 = 32'sd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        test_reset();
        test_edges();
        test_back_to_back();
`ifdef TRI_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
